// File: rtl/red_ghost_pixel_gen_if.sv
// Pixel-fetch bus for the red ghost: scan/ghost state in, sprite ROM port, palette index out.
interface red_ghost_pixel_gen_if #(
  parameter int ADDR_W = 11
);
  logic              frame_start;
  logic              pause;
  logic [9:0]        ghost_x;
  logic [9:0]        ghost_y;
  logic [1:0]        dir;
  logic [9:0]        draw_x;
  logic [9:0]        draw_y;
  logic              pix_valid;
  logic [ADDR_W-1:0] rom_addr;
  logic [4:0]        rom_data;
  logic [4:0]        pal_index;
  logic              ghost_hit;
  logic              out_valid;

  modport master (
    output frame_start, pause, ghost_x, ghost_y, dir, draw_x, draw_y, pix_valid, rom_data,
    input  rom_addr, pal_index, ghost_hit, out_valid
  );

  modport slave (
    input  frame_start, pause, ghost_x, ghost_y, dir, draw_x, draw_y, pix_valid, rom_data,
    output rom_addr, pal_index, ghost_hit, out_valid
  );
endinterface

// File: rtl/red_ghost_pixel_gen.sv
// Red ghost sprite fetch: frame-latched position/direction, walk animation timer, 2-cycle ROM fetch.
// Optional macro RED_GHOST_MIRROR_EN: left-facing frames come from mirrored right-facing columns.
module red_ghost_pixel_gen #(
  parameter int SPRITE_W        = 16,
  parameter int SPRITE_H        = 16,
  parameter int ANIM_DIV        = 8,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  red_ghost_pixel_gen_if.slave bus
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic signed [10:0] W_MAX = 11'(SPRITE_W - 1);
  localparam logic signed [10:0] H_MAX = 11'(SPRITE_H - 1);

  function automatic logic in_range(input logic signed [10:0] v, input logic signed [10:0] hi);
    return (v >= 11'sd0) && (v <= hi);
  endfunction

  logic [9:0]    shadow_x_q, shadow_x_d;
  logic [9:0]    shadow_y_q, shadow_y_d;
  logic [1:0]    shadow_dir_q, shadow_dir_d;
  logic [CW-1:0] anim_cnt_q, anim_cnt_d;
  logic          anim_phase_q, anim_phase_d;

  always_comb begin
    shadow_x_d   = shadow_x_q;
    shadow_y_d   = shadow_y_q;
    shadow_dir_d = shadow_dir_q;
    anim_cnt_d   = anim_cnt_q;
    anim_phase_d = anim_phase_q;
    if (bus.frame_start) begin
      shadow_x_d   = bus.ghost_x;
      shadow_y_d   = bus.ghost_y;
      shadow_dir_d = bus.dir;
      if (!bus.pause) begin
        if (anim_cnt_q == CW'(ANIM_DIV - 1)) begin
          anim_cnt_d   = '0;
          anim_phase_d = ~anim_phase_q;
        end else begin
          anim_cnt_d = anim_cnt_q + 1'b1;
        end
      end
    end
  end

  // Stage 0: box test and ROM address from the frame-latched ghost state
  logic signed [10:0] dx_p0, dy_p0;
  logic [XW-1:0]      col_p0;
  logic [YW-1:0]      row_p0;
  logic [1:0]         dir_p0;
  logic               in_box_p0;
  logic [ADDR_W-1:0]  addr_p0;

  always_comb begin
    dx_p0     = $signed({1'b0, bus.draw_x} - {1'b0, shadow_x_q});
    dy_p0     = $signed({1'b0, bus.draw_y} - {1'b0, shadow_y_q});
    in_box_p0 = bus.pix_valid & in_range(dx_p0, W_MAX) & in_range(dy_p0, H_MAX);
    col_p0    = dx_p0[XW-1:0];
    row_p0    = dy_p0[YW-1:0];
    dir_p0    = shadow_dir_q;
`ifdef RED_GHOST_MIRROR_EN
    if (shadow_dir_q == 2'd1) begin
      dir_p0 = 2'd0;
      col_p0 = XW'(SPRITE_W - 1) - dx_p0[XW-1:0];
    end
`endif
    addr_p0 = ADDR_W'({dir_p0, anim_phase_q, row_p0, col_p0});
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              in_box_p1_q, vld_p1_q;
  logic [4:0]        pal_p2_q;
  logic              hit_p2_q, vld_p2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      shadow_dir_q <= '0;
      anim_cnt_q   <= '0;
      anim_phase_q <= 1'b0;
      rom_addr_q   <= '0;
      in_box_p1_q  <= 1'b0;
      vld_p1_q     <= 1'b0;
      pal_p2_q     <= '0;
      hit_p2_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
    end else begin
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      shadow_dir_q <= shadow_dir_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_phase_q <= anim_phase_d;
      rom_addr_q   <= addr_p0;
      in_box_p1_q  <= in_box_p0;
      vld_p1_q     <= bus.pix_valid;
      // Stage 1 -> 2: ROM data is valid now; register the palette result
      pal_p2_q     <= in_box_p1_q ? bus.rom_data : 5'd0;
      hit_p2_q     <= in_box_p1_q & (bus.rom_data != 5'(TRANSPARENT_IDX));
      vld_p2_q     <= vld_p1_q;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pal_index = pal_p2_q;
  assign bus.ghost_hit = hit_p2_q;
  assign bus.out_valid = vld_p2_q;
endmodule

// File: tb/tb_red_ghost_pixel_gen.sv
// Bench for red_ghost_pixel_gen: directed steps plus randomized scan against a frame-level model.
module tb_red_ghost_pixel_gen;
  localparam int ANIM_DIV = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  red_ghost_pixel_gen_if #(.ADDR_W(11)) bus ();

  red_ghost_pixel_gen #(
    .SPRITE_W(16), .SPRITE_H(16), .ANIM_DIV(ANIM_DIV), .TRANSPARENT_IDX(0), .ADDR_W(11)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [4:0] rom_mem [0:2047];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  typedef struct packed {
    logic [10:0] addr;
    logic [4:0]  pal;
    logic        hit;
    logic        vld;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   sx, sy, sdir, frames;
  exp_t h0, h1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sprite placement rules expressed in screen arithmetic
  function automatic exp_t predict(input int x, input int y, input logic pv);
    exp_t e;
    int dx, dy, col, row, d, ph;
    logic inb;
    dx  = x - sx;
    dy  = y - sy;
    col = dx & 15;
    row = dy & 15;
    d   = sdir;
    ph  = (frames / ANIM_DIV) % 2;
`ifdef RED_GHOST_MIRROR_EN
    if (d == 1) begin
      d   = 0;
      col = 15 - col;
    end
`endif
    e.addr = 11'(d * 512 + ph * 256 + row * 16 + col);
    inb    = pv && (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16);
    e.pal  = inb ? rom_mem[e.addr] : 5'd0;
    e.hit  = inb && (rom_mem[e.addr] != 5'd0);
    e.vld  = pv;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    e = predict(int'(bus.draw_x), int'(bus.draw_y), bus.pix_valid);
    @(posedge clk);
    if (!reset_n) begin
      h0 = '0; h1 = '0;
      sx = 0; sy = 0; sdir = 0; frames = 0;
    end else begin
      h1 = h0;
      h0 = e;
      if (bus.frame_start) begin
        if (!bus.pause) frames++;
        sx = int'(bus.ghost_x); sy = int'(bus.ghost_y); sdir = int'(bus.dir);
      end
    end
    @(negedge clk);
    check("rom_addr", 32'(bus.rom_addr), 32'(h0.addr));
    check("pal_index", 32'(bus.pal_index), 32'(h1.pal));
    check("ghost_hit", 32'(bus.ghost_hit), 32'(h1.hit));
    check("out_valid", 32'(bus.out_valid), 32'(h1.vld));
  endtask

  task automatic pix(input int x, input int y);
    bus.draw_x = 10'(x); bus.draw_y = 10'(y); bus.pix_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input int gx, input int gy, input int d);
    bus.ghost_x = 10'(gx); bus.ghost_y = 10'(gy); bus.dir = 2'(d);
    bus.frame_start = 1'b1; bus.pix_valid = 1'b0;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic fill_rom(input logic rnd);
    for (int i = 0; i < 2048; i++) rom_mem[i] = rnd ? 5'($urandom) : 5'h01;
  endtask

  initial begin
    exp_t t;
    int x, y;
    fill_rom(1'b1);
    sx = 0; sy = 0; sdir = 0; frames = 0; h0 = '0; h1 = '0;
    reset_n = 1'b0;
    bus.frame_start = 0; bus.pause = 0; bus.ghost_x = 0; bus.ghost_y = 0; bus.dir = 0;
    bus.draw_x = 0; bus.draw_y = 0; bus.pix_valid = 0;
    @(negedge clk);
    tick(); tick();
    reset_n = 1'b1;
    idle(2);

    // first capture and fetch
    frame(100, 50, 0);
    pix(100, 50);
    check("addr_origin", 32'(bus.rom_addr), 32'd0);
    idle(2);

    // box edges with opaque ROM
    fill_rom(1'b0);
    pix(99, 50); pix(100, 50); pix(115, 50);
    check("addr_x115", 32'(bus.rom_addr), 32'd15);
    pix(116, 50);
    idle(2);

    // transparency and right-edge clipping
    t = predict(103, 52, 1'b1);
    rom_mem[t.addr] = 5'd0;
    pix(103, 52); pix(104, 52);
    idle(2);
    frame(630, 50, 0);
    pix(639, 50); pix(0, 50); pix(640, 50);
    idle(2);

    // walk animation, then paused
    frame(100, 50, 0);
    for (int i = 0; i < 7; i++) frame(100, 50, 0);
    pix(101, 51);
    check("anim_bit8", 32'(bus.rom_addr[8]), 32'd1);
    idle(2);
    bus.pause = 1'b1;
    for (int i = 0; i < 8; i++) frame(100, 50, 0);
    bus.pause = 1'b0;
    pix(101, 51);
    check("anim_hold", 32'(bus.rom_addr[8]), 32'd1);
    idle(2);

    // tear-free position update
    frame(100, 50, 0);
    bus.ghost_x = 10'd200;
    pix(100, 50); pix(200, 50);
    bus.frame_start = 1'b1;
    pix(100, 50);
    bus.frame_start = 1'b0;
    pix(200, 50); pix(100, 50);
    idle(2);

    // reset in the middle of a scan line discards in-flight pixels
    pix(200, 50); pix(201, 50);
    reset_n = 1'b0;
    pix(202, 50);
    reset_n = 1'b1;
    idle(2);

    // left-facing fetch
    frame(100, 50, 1);
    pix(100, 50);
`ifdef RED_GHOST_MIRROR_EN
    check("addr_left", 32'(bus.rom_addr), 32'd15);
`else
    check("addr_left", 32'(bus.rom_addr), 32'd512);
`endif
    idle(2);

    // randomized frames and scans
    fill_rom(1'b1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.pause = 1'($urandom_range(0, 1));
        bus.ghost_x = 10'($urandom_range(0, 639));
        bus.ghost_y = 10'($urandom_range(0, 479));
        bus.dir = 2'($urandom_range(0, 3));
        bus.frame_start = 1'b1;
      end
      x = sx + int'($urandom_range(0, 23)) - 4;
      y = sy + int'($urandom_range(0, 23)) - 4;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      bus.draw_x = 10'(x); bus.draw_y = 10'(y);
      bus.pix_valid = ($urandom_range(0, 7) != 0);
      tick();
      bus.frame_start = 1'b0;
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/red_ghost_pixel_gen.md
Name: red_ghost_pixel_gen

Overview:
Per-pixel sprite fetch stage for the red ghost. It sits directly upstream of the red ghost palette lookup. It takes the VGA scan coordinates and the ghost's position, direction and animation state, and addresses the red ghost sprite ROM. It then emits the registered 5-bit palette index plus a hit flag to the palette lookup and the pixel mux. Position and direction are captured once per frame to prevent tearing, and the block owns the two-frame walk-animation timer.

Parameters:
SPRITE_W, 16, sprite width in pixels (power of two)
SPRITE_H, 16, sprite height in pixels (power of two)
ANIM_DIV, 8, video frames per animation toggle (>=1)
TRANSPARENT_IDX, 0, palette index treated as see-through
ADDR_W, 11, ROM address width: 4 dirs x 2 anim x SPRITE_H x SPRITE_W

Ports:
clk  in  1  pixel clock
reset_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pause  in  1  freeze walk animation while high
ghost_x  in  10  sprite top-left X, screen pixels
ghost_y  in  10  sprite top-left Y
dir  in  2  0=right 1=left 2=up 3=down
draw_x  in  10  current scan X
draw_y  in  10  current scan Y
pix_valid  in  1  draw_x/draw_y inside active video
rom_addr  out  ADDR_W  sprite ROM address, registered
rom_data  in  5  ROM read data, exactly 1 cycle after rom_addr
pal_index  out  5  palette index for the red ghost palette
ghost_hit  out  1  pixel belongs to an opaque ghost pixel
out_valid  out  1  pal_index/ghost_hit correspond to a valid pixel

Behaviour:
- Reset (reset_n=0 at a clk edge): pal_index=0, ghost_hit=0, out_valid=0, rom_addr=0. Shadow x/y=0, shadow dir=0, anim_cnt=0, anim_phase=0. Reset applied mid-frame discards all in-flight pixels.
- Shadow registers: on frame_start, shadow_x/shadow_y/shadow_dir <= ghost_x/ghost_y/dir. Stage 0 always uses the shadow values. If a pixel arrives in the same cycle as frame_start, it uses the old shadow values.
- Animation: on frame_start with pause=0, anim_cnt increments. When anim_cnt reaches ANIM_DIV-1, it wraps to 0 and anim_phase toggles. With pause=1 both hold. The shadow capture still occurs while paused.
- Stage 0 (cycle N): dx = {1'b0,draw_x} - {1'b0,shadow_x}, 11-bit two's complement; dy likewise.
- in_box = pix_valid & dx in [0,SPRITE_W-1] & dy in [0,SPRITE_H-1]. There is no wrap: a sprite past X=639 simply clips.
- rom_addr <= {shadow_dir, anim_phase, dy[log2 H-1:0], dx[log2 W-1:0]}.
- in_box and pix_valid are registered alongside rom_addr.
- rom_addr updates every cycle, including out-of-box pixels; its content is don't-care when in_box=0.
- Stage 1 (cycle N+1): rom_data is valid. The in_box and pix_valid flags advance one more register.
- Stage 2 (output, cycle N+2): pal_index <= in_box ? rom_data : 0. ghost_hit <= in_box & (rom_data != TRANSPARENT_IDX). out_valid <= pix_valid.
- Total latency from draw_x/draw_y to pal_index is 2 cycles. Throughput is 1 pixel per cycle, with no stalls and no backpressure.
- Transparent pixels inside the box: pal_index=TRANSPARENT_IDX, ghost_hit=0.
- Outside the box: pal_index=0, ghost_hit=0.

Optional Feature:
RED_GHOST_MIRROR_EN
- Defined: dir=1 (left) fetches the right-facing frames with the column mirrored. The address uses dir field 0 and column = SPRITE_W-1-dx. Left-frame ROM rows are unused. Latency, hit rules and all other directions are unchanged.
- Undefined: dir selects its own frames directly, as in Behaviour.

Test Plan:
- Reset, then shadow capture: reset_n low 2 cycles then high; pulse frame_start with ghost_x=100, ghost_y=50, dir=0. Then scan draw_x=100, draw_y=50 with pix_valid=1. Required: rom_addr=0 one cycle later; pal_index=rom_data and out_valid=1 at N+2. Before the pulse, all outputs are 0.
- Box edges: shadow at (100,50); scan draw_x 99, 100, 115, 116 on row 50 with a ROM returning 5'h01. Required: ghost_hit = 0, 1, 1, 0 at 2-cycle latency; rom_addr for x=115 is 15.
- Transparency and clipping: ROM returns 0 at an in-box pixel -> ghost_hit=0, pal_index=0. Ghost_x=630, draw_x=639 -> hit. Draw_x=0 -> no hit (no wrap).
- Animation: ANIM_DIV=8, pause=0; 8 frame_start pulses -> anim_phase 0->1, and address bit 8 set on subsequent fetches. Pause=1 during 8 more pulses -> anim_phase stays 1.
- Tear-free update: change ghost_x from 100 to 200 mid-frame, with no frame_start. Pixel x=100 still hits; x=200 hits only after the next frame_start. A pixel sampled in the frame_start cycle uses x=100.
- Mirror (RED_GHOST_MIRROR_EN defined): dir=1, dx=0, dy=0 -> rom_addr = 15. Undefined -> rom_addr = {2'd1,anim_phase,8'd0} = 512.
